shared_fn_scheduler: RTL

- Time-multiplexes one external expensive-function unit (pipelined, fixed or variable latency, tagged results) among N_LANE independent requester lanes.
- Replaces per-lane replicated instances of the expensive function. Sits between per-element lane logic and a single shared compute pipeline.
- Lanes use valid/ready handshakes. Results are routed back by tag, and each lane has at most one request in flight.

---
 rtl/shared_fn_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/shared_fn_scheduler.sv
// shared_fn_scheduler
//   Time-multiplexes one pipelined, tagged expensive-function unit among
//   N_LANE requester lanes. Each lane runs IDLE -> PEND -> FLIGHT -> DONE
//   and has at most one request in flight. A round-robin arbiter picks
//   which PEND lane issues. Results come back by tag and are routed to the
//   owning lane.
//
//   Optional build macro SHARED_FN_SCHEDULER_MEMO_EN: each lane remembers
//   its last completed argument/result pair. A repeat request with the same
//   argument goes straight to DONE without using the shared unit.
//
// Ports
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_req_valid/o_req_ready/i_req_arg   per-lane request handshake + argument
//   o_rsp_valid/i_rsp_ready/o_rsp_res   per-lane result handshake + result
//   o_fn_valid/i_fn_ready/o_fn_arg/o_fn_tag   issue to shared unit
//   i_fn_rvalid/i_fn_rtag/i_fn_res      tagged return from shared unit
//   o_err              sticky: return with a bad tag or for a lane not in flight

module shared_fn_scheduler #(
  parameter int unsigned N_LANE = 5,
  parameter int unsigned ARG_W  = 8,
  parameter int unsigned RES_W  = 8,
  localparam int unsigned TAG_W = (N_LANE > 1) ? $clog2(N_LANE) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_LANE-1:0]         i_req_valid,
  output logic [N_LANE-1:0]         o_req_ready,
  input  logic [N_LANE*ARG_W-1:0]   i_req_arg,
  output logic [N_LANE-1:0]         o_rsp_valid,
  input  logic [N_LANE-1:0]         i_rsp_ready,
  output logic [N_LANE*RES_W-1:0]   o_rsp_res,
  output logic                      o_fn_valid,
  input  logic                      i_fn_ready,
  output logic [ARG_W-1:0]          o_fn_arg,
  output logic [TAG_W-1:0]          o_fn_tag,
  input  logic                      i_fn_rvalid,
  input  logic [TAG_W-1:0]          i_fn_rtag,
  input  logic [RES_W-1:0]          i_fn_res,
  output logic                      o_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_FLIGHT = 2'd2,
    S_DONE   = 2'd3
  } lane_st_e;

  lane_st_e               state_q [N_LANE];
  logic [ARG_W-1:0]       arg_q   [N_LANE];
  logic [RES_W-1:0]       res_q   [N_LANE];
  logic [TAG_W-1:0]       rr_ptr_q;
  logic                   err_q;

`ifdef SHARED_FN_SCHEDULER_MEMO_EN
  logic [ARG_W-1:0]       last_arg_q [N_LANE];
  logic [RES_W-1:0]       last_res_q [N_LANE];
  logic [N_LANE-1:0]      memo_vld_q;
`endif

  logic                   any_pend;
  logic [TAG_W-1:0]       grant;
  logic                   issue;
  logic [N_LANE-1:0]      ret_hit;
  logic                   ret_err;

  // Round-robin search starting at rr_ptr_q; depends on registered state
  // only, so the grant stays put while the unit stalls unless a lane that
  // ranks ahead of it enters PEND.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    any_pend = 1'b0;
    grant    = '0;
    for (int unsigned k = 0; k < N_LANE; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_LANE) idx = idx - N_LANE;
      if (!any_pend && state_q[idx] == S_PEND) begin
        any_pend = 1'b1;
        grant    = TAG_W'(idx);
      end
    end
  end

  assign issue = any_pend && i_fn_ready;

  // A return is accepted only for a lane currently in FLIGHT; anything else
  // (out-of-range tag, lane in another state) flags an error and is dropped.
  always_comb begin
    ret_hit = '0;
    ret_err = 1'b0;
    if (i_fn_rvalid) begin
      ret_err = 1'b1;
      for (int unsigned i = 0; i < N_LANE; i++) begin
        if (32'(i_fn_rtag) == i && state_q[i] == S_FLIGHT) begin
          ret_hit[i] = 1'b1;
          ret_err    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < N_LANE; i++) begin
        state_q[i] <= S_IDLE;
        arg_q[i]   <= '0;
        res_q[i]   <= '0;
`ifdef SHARED_FN_SCHEDULER_MEMO_EN
        last_arg_q[i] <= '0;
        last_res_q[i] <= '0;
`endif
      end
`ifdef SHARED_FN_SCHEDULER_MEMO_EN
      memo_vld_q <= '0;
`endif
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_LANE; i++) begin
        unique case (state_q[i])
          S_IDLE: begin
            if (i_req_valid[i]) begin
              arg_q[i] <= i_req_arg[i*ARG_W +: ARG_W];
`ifdef SHARED_FN_SCHEDULER_MEMO_EN
              if (memo_vld_q[i] && i_req_arg[i*ARG_W +: ARG_W] == last_arg_q[i]) begin
                res_q[i]   <= last_res_q[i];
                state_q[i] <= S_DONE;
              end else begin
                state_q[i] <= S_PEND;
              end
`else
              state_q[i] <= S_PEND;
`endif
            end
          end
          S_PEND: begin
            if (issue && grant == TAG_W'(i)) state_q[i] <= S_FLIGHT;
          end
          S_FLIGHT: begin
            if (ret_hit[i]) begin
              res_q[i]   <= i_fn_res;
              state_q[i] <= S_DONE;
`ifdef SHARED_FN_SCHEDULER_MEMO_EN
              last_arg_q[i] <= arg_q[i];
              last_res_q[i] <= i_fn_res;
              memo_vld_q[i] <= 1'b1;
`endif
            end
          end
          S_DONE: begin
            if (i_rsp_ready[i]) state_q[i] <= S_IDLE;
          end
          default: state_q[i] <= S_IDLE;
        endcase
      end
      if (issue) rr_ptr_q <= (grant == TAG_W'(N_LANE - 1)) ? '0 : grant + TAG_W'(1);
      if (ret_err) err_q <= 1'b1;
    end
  end

  // Lane-facing outputs are pure decodes of registered state.
  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_rsp_res   = '0;
    for (int unsigned i = 0; i < N_LANE; i++) begin
      o_req_ready[i]               = (state_q[i] == S_IDLE);
      o_rsp_valid[i]               = (state_q[i] == S_DONE);
      o_rsp_res[i*RES_W +: RES_W]  = res_q[i];
    end
  end

  assign o_fn_valid = any_pend;
  assign o_fn_tag   = grant;
  assign o_fn_arg   = any_pend ? arg_q[grant] : '0;
  assign o_err      = err_q;

endmodule
